// File: rtl/tick_timer_ctrl_pkg.sv
// rtl/tick_timer_ctrl_pkg.sv - shared state encoding and default width for the tick timer
package tick_timer_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 26;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/tick_timer_ctrl_tick_counter.sv
// rtl/tick_timer_ctrl_tick_counter.sv - interval counter with clear, enable and terminal compare
module tick_counter
  import tick_timer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             eq
);

  // Cleared on reaching the limit, so count never passes it and the add cannot wrap.
  always_ff @(posedge CLK) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign eq = (count == limit);

endmodule

// File: rtl/tick_timer_ctrl.sv
// rtl/tick_timer_ctrl.sv - start/stop interval timer with periodic/one-shot tick and toggle outputs
module tick_timer_ctrl
  import tick_timer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] period,
  output logic             busy,
  output logic             tick,
  output logic             toggle,
  output logic             expired,
  output logic [WIDTH-1:0] count
);

  logic [1:0]       state;
  logic [WIDTH-1:0] p_q;
  logic             m_q;
  logic             run;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_eq;

  assign run  = (state == ST_RUN);
  assign busy = run;

  // Any control event, leaving RUN, or hitting the terminal count returns the counter to 0.
  assign cnt_clr = RESET | stop | start | ~run | cnt_eq;
  assign cnt_en  = ~cnt_clr;

  tick_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .CLK   (CLK),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (p_q),
    .count (count),
    .eq    (cnt_eq)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= ST_IDLE;
      p_q     <= '0;
      m_q     <= 1'b0;
      tick    <= 1'b0;
      toggle  <= 1'b0;
      expired <= 1'b0;
    end else if (stop) begin
      state   <= ST_IDLE;
      tick    <= 1'b0;
      expired <= 1'b0;
    end else if (start) begin
      // Restart from any state; a tick due this cycle is dropped.
      state   <= ST_RUN;
      p_q     <= period;
      m_q     <= periodic;
      tick    <= 1'b0;
      expired <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (cnt_eq) begin
            tick   <= 1'b1;
            toggle <= ~toggle;
            if (!m_q) begin
              state   <= ST_DONE;
              expired <= 1'b1;
            end
          end else begin
            tick <= 1'b0;
          end
        end
        ST_IDLE, ST_DONE: begin
          tick <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          tick    <= 1'b0;
          expired <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// tb/tb_tick_timer_ctrl.sv - self-checking bench for tick_timer_ctrl with reference model
module tb_tick_timer_ctrl;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         periodic = 1'b0;
  logic [W-1:0] period = '0;
  logic         busy;
  logic         tick;
  logic         toggle;
  logic         expired;
  logic [W-1:0] count;

  int checks = 0;
  int errors = 0;

  tick_timer_ctrl #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .period   (period),
    .busy     (busy),
    .tick     (tick),
    .toggle   (toggle),
    .expired  (expired),
    .count    (count)
  );

  always #5 CLK = ~CLK;

  // Reference: mode 0 idle, 1 running, 2 finished; el = cycles since the last accepted start.
  typedef struct packed {
    int       mode;
    int       p;
    bit       m;
    int       el;
    bit       tk;
    bit       tg;
  } model_t;

  model_t mdl = '0;
  bit     started = 1'b0;

  function automatic model_t model_next(input model_t c, input bit r, input bit sa,
                                        input bit so, input bit pm, input int pp);
    model_t n;
    n = c;
    n.tk = 1'b0;
    if (r) begin
      n = '0;
    end else if (so) begin
      n.mode = 0;
      n.el   = 0;
    end else if (sa) begin
      n.mode = 1;
      n.p    = pp;
      n.m    = pm;
      n.el   = 0;
    end else if (c.mode == 1) begin
      n.el = c.el + 1;
      if (n.el % (c.p + 1) == 0) begin
        n.tk = 1'b1;
        n.tg = ~c.tg;
        if (!c.m) n.mode = 2;
      end
    end
    return n;
  endfunction

  always @(posedge CLK) begin
    mdl     <= model_next(mdl, RESET, start, stop, periodic, int'(period));
    started <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (started) begin
      chk("m_busy",    32'(busy),    32'(mdl.mode == 1));
      chk("m_expired", 32'(expired), 32'(mdl.mode == 2));
      chk("m_tick",    32'(tick),    32'(mdl.tk));
      chk("m_toggle",  32'(toggle),  32'(mdl.tg));
      chk("m_count",   32'(count),   (mdl.mode == 1) ? 32'(mdl.el % (mdl.p + 1)) : 32'd0);
    end
  end

  task automatic step(input bit r, input bit sa, input bit so, input bit pm, input int pp);
    RESET    = r;
    start    = sa;
    stop     = so;
    periodic = pm;
    period   = W'(pp);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    @(negedge CLK);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_toggle", 32'(toggle), 0);
    chk("rst_expired", 32'(expired), 0);
    chk("rst_count", 32'(count), 0);

    // Periodic P=3; period input wiggled to show it is ignored while running.
    step(0, 1, 0, 1, 3);
    for (int c = 1; c <= 12; c++) begin
      step(0, 0, 0, 0, 9);
      chk("p3_tick", 32'(tick), 32'(c % 4 == 0));
      chk("p3_count", 32'(count), 32'(c % 4));
      chk("p3_busy", 32'(busy), 1);
      if (c == 4)  chk("p3_toggle4", 32'(toggle), 1);
      if (c == 8)  chk("p3_toggle8", 32'(toggle), 0);
      if (c == 12) chk("p3_toggle12", 32'(toggle), 1);
    end

    // One-shot P=5, then a second start repeats it.
    step(0, 1, 0, 0, 5);
    for (int c = 1; c <= 26; c++) begin
      step(0, 0, 0, 0, 0);
      chk("os_tick", 32'(tick), 32'(c == 6));
      chk("os_expired", 32'(expired), 32'(c >= 6));
      chk("os_busy", 32'(busy), 32'(c < 6));
    end
    step(0, 1, 0, 0, 5);
    chk("os2_expired", 32'(expired), 0);
    chk("os2_busy", 32'(busy), 1);
    for (int c = 1; c <= 7; c++) begin
      step(0, 0, 0, 0, 0);
      chk("os2_tick", 32'(tick), 32'(c == 6));
    end

    // Stop mid-run, then start+stop collision from idle.
    step(0, 1, 0, 1, 9);
    for (int c = 1; c <= 3; c++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_count", 32'(count), 0);
    for (int c = 1; c <= 15; c++) begin
      step(0, 0, 0, 0, 0);
      chk("stop_tick", 32'(tick), 0);
    end
    step(0, 1, 1, 1, 9);
    chk("coll_busy", 32'(busy), 0);
    chk("coll_count", 32'(count), 0);

    // Restart: period change without start is ignored; start at count 6 suppresses the tick.
    step(0, 1, 0, 1, 7);
    for (int c = 1; c <= 14; c++) begin
      step(0, 0, 0, 1, 2);
      chk("rs_tick", 32'(tick), 32'(c == 8));
    end
    chk("rs_count6", 32'(count), 6);
    step(0, 1, 0, 1, 2);
    chk("rs_restart_tick", 32'(tick), 0);
    chk("rs_restart_count", 32'(count), 0);
    for (int c = 1; c <= 6; c++) begin
      step(0, 0, 0, 0, 0);
      chk("rs_new_tick", 32'(tick), 32'(c % 3 == 0));
    end

    // P=0 from a fresh reset: tick every cycle, toggle alternates.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    chk("p0_tick0", 32'(tick), 0);
    for (int c = 1; c <= 6; c++) begin
      step(0, 0, 0, 0, 0);
      chk("p0_tick", 32'(tick), 1);
      chk("p0_toggle", 32'(toggle), 32'(c % 2));
      chk("p0_count", 32'(count), 0);
    end

    // Full-range period: 16-cycle interval, count 15 then 0.
    step(0, 1, 0, 1, 15);
    for (int c = 1; c <= 17; c++) begin
      step(0, 0, 0, 0, 0);
      chk("p15_count", 32'(count), 32'(c % 16));
      chk("p15_tick", 32'(tick), 32'(c == 16));
    end

    // Reset together with start at count P-1.
    step(0, 1, 0, 1, 3);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rm_count2", 32'(count), 2);
    step(1, 1, 0, 1, 3);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_tick", 32'(tick), 0);
    chk("rm_toggle", 32'(toggle), 0);
    chk("rm_expired", 32'(expired), 0);
    chk("rm_count", 32'(count), 0);
    step(0, 0, 0, 0, 0);
    chk("rm_tick_after", 32'(tick), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 39) == 0,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
